// File: rtl/ps2_mouse_reg_arbiter.sv
// ps2_mouse_reg_arbiter
//
// Sequences and arbitrates accesses from two requesters (port 0: CPU bus bridge,
// port 1: cursor overlay) onto the single port of the PS/2 mouse register file.
// Grants are round-robin on a one-bit last-grant pointer. Only one access is in
// flight at a time. The write strobe is bracketed by SETUP and HOLD cycles, so the
// address and data are stable around both strobe edges.
//
// Optional feature (compile-time macro):
//   PS2_ARB_OVERLAY_WRPROT_EN - when defined, port 1 writes are rejected with Err1.
//
// Parameters:
//   NUM_REGS       number of implemented registers; higher addresses are rejected
//   STROBE_CYCLES  cycles the write strobe stays high (1..15)
//
// Ports:
//   Clk, Reset                  clock, synchronous active-low reset
//   Req/Wr/Addr/WData{0,1}      per-requester command
//   Ack/Err/RData{0,1}          per-requester completion, error flag, read data
//   RegReadAddress, RegWriteAddress, RegDataIn, RegWriteData
//                               register file control (all registered)
//   RegDataOut                  register file read data (combinational)
module ps2_mouse_reg_arbiter #(
  parameter int unsigned NUM_REGS      = 5,
  parameter int unsigned STROBE_CYCLES = 1
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Req0,
  input  logic        Req1,
  input  logic        Wr0,
  input  logic        Wr1,
  input  logic [7:0]  Addr0,
  input  logic [7:0]  Addr1,
  input  logic [31:0] WData0,
  input  logic [31:0] WData1,
  output logic        Ack0,
  output logic        Ack1,
  output logic        Err0,
  output logic        Err1,
  output logic [31:0] RData0,
  output logic [31:0] RData1,
  output logic [7:0]  RegReadAddress,
  output logic [7:0]  RegWriteAddress,
  output logic [31:0] RegDataIn,
  output logic        RegWriteData,
  input  logic [31:0] RegDataOut
);

  localparam logic [3:0] StrobeLast = 4'(STROBE_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StCapture,
    StStrobe,
    StHold,
    StDone
  } state_e;

  state_e      state_q;
  logic        last_q;   // port granted last; reset to 1 so port 0 wins the first tie
  logic        port_q;
  logic        wr_q;
  logic [3:0]  cnt_q;
  logic        ack0_q, ack1_q, err0_q, err1_q;
  logic        strobe_q;
  logic [31:0] rdata0_q, rdata1_q;
  logic [7:0]  raddr_q, waddr_q;
  logic [31:0] wdata_q;

  // Grant decode, only acted on in StIdle.
  logic        gnt_valid;
  logic        gnt_port;
  logic        gnt_wr;
  logic        gnt_reject;
  logic [7:0]  gnt_addr;
  logic [31:0] gnt_wdata;

  always_comb begin
    gnt_valid = Req0 | Req1;
    if (Req0 && Req1) begin
      gnt_port = ~last_q;
    end else begin
      gnt_port = Req1;
    end
    gnt_wr     = gnt_port ? Wr1 : Wr0;
    gnt_addr   = gnt_port ? Addr1 : Addr0;
    gnt_wdata  = gnt_port ? WData1 : WData0;
    gnt_reject = 32'(gnt_addr) >= NUM_REGS;
`ifdef PS2_ARB_OVERLAY_WRPROT_EN
    if (gnt_port && gnt_wr) begin
      gnt_reject = 1'b1;
    end
`else
`endif
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q  <= StIdle;
      last_q   <= 1'b1;
      port_q   <= 1'b0;
      wr_q     <= 1'b0;
      cnt_q    <= '0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      err0_q   <= 1'b0;
      err1_q   <= 1'b0;
      strobe_q <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      raddr_q  <= '0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (gnt_valid) begin
            last_q <= gnt_port;
            port_q <= gnt_port;
            wr_q   <= gnt_wr;
            if (gnt_reject) begin
              // Rejected: complete immediately, register file untouched.
              state_q <= StDone;
              if (gnt_port) begin
                ack1_q   <= 1'b1;
                err1_q   <= 1'b1;
                rdata1_q <= '0;
              end else begin
                ack0_q   <= 1'b1;
                err0_q   <= 1'b1;
                rdata0_q <= '0;
              end
            end else begin
              state_q <= StSetup;
              if (gnt_wr) begin
                waddr_q <= gnt_addr;
                wdata_q <= gnt_wdata;
              end else begin
                raddr_q <= gnt_addr;
              end
            end
          end
        end
        StSetup: begin
          if (wr_q) begin
            strobe_q <= 1'b1;
            cnt_q    <= StrobeLast;
            state_q  <= StStrobe;
          end else begin
            state_q <= StCapture;
          end
        end
        StCapture: begin
          state_q <= StDone;
          if (port_q) begin
            ack1_q   <= 1'b1;
            rdata1_q <= RegDataOut;
          end else begin
            ack0_q   <= 1'b1;
            rdata0_q <= RegDataOut;
          end
        end
        StStrobe: begin
          if (cnt_q == 4'd0) begin
            strobe_q <= 1'b0;
            state_q  <= StHold;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StHold: begin
          state_q <= StDone;
          if (port_q) begin
            ack1_q <= 1'b1;
          end else begin
            ack0_q <= 1'b1;
          end
        end
        StDone: begin
          ack0_q  <= 1'b0;
          ack1_q  <= 1'b0;
          err0_q  <= 1'b0;
          err1_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign Ack0            = ack0_q;
  assign Ack1            = ack1_q;
  assign Err0            = err0_q;
  assign Err1            = err1_q;
  assign RData0          = rdata0_q;
  assign RData1          = rdata1_q;
  assign RegReadAddress  = raddr_q;
  assign RegWriteAddress = waddr_q;
  assign RegDataIn       = wdata_q;
  assign RegWriteData    = strobe_q;

endmodule

// File: tb/tb_ps2_mouse_reg_arbiter.sv
// Testbench for ps2_mouse_reg_arbiter: a default instance backed by a behavioural
// register file, plus a STROBE_CYCLES=3 instance for strobe-width checks.
`timescale 1ns/1ps
module tb_ps2_mouse_reg_arbiter;

`ifdef PS2_ARB_OVERLAY_WRPROT_EN
  localparam bit Wp = 1'b1;
`else
  localparam bit Wp = 1'b0;
`endif

  logic        Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic        Reset;
  logic        Req0, Req1, Wr0, Wr1;
  logic [7:0]  Addr0, Addr1;
  logic [31:0] WData0, WData1;
  logic        Ack0, Ack1, Err0, Err1;
  logic [31:0] RData0, RData1;
  logic [7:0]  RegReadAddress, RegWriteAddress;
  logic [31:0] RegDataIn, RegDataOut;
  logic        RegWriteData;

  ps2_mouse_reg_arbiter dut (
    .Clk(Clk), .Reset(Reset),
    .Req0(Req0), .Req1(Req1), .Wr0(Wr0), .Wr1(Wr1),
    .Addr0(Addr0), .Addr1(Addr1), .WData0(WData0), .WData1(WData1),
    .Ack0(Ack0), .Ack1(Ack1), .Err0(Err0), .Err1(Err1),
    .RData0(RData0), .RData1(RData1),
    .RegReadAddress(RegReadAddress), .RegWriteAddress(RegWriteAddress),
    .RegDataIn(RegDataIn), .RegWriteData(RegWriteData), .RegDataOut(RegDataOut)
  );

  // Behavioural register file: captures on the rising edge of the strobe.
  logic [31:0] regs [0:7] = '{default: 32'h0};
  always @(posedge RegWriteData) begin
    if (RegWriteAddress < 8'd5) regs[RegWriteAddress[2:0]] = RegDataIn;
  end
  assign RegDataOut = (RegReadAddress < 8'd5) ? regs[RegReadAddress[2:0]] : 32'h0;

  // Second instance with a 3-cycle strobe.
  logic        req_b, wr_b;
  logic [7:0]  addr_b;
  logic [31:0] wdata_b;
  logic        ack0_b, ack1_b, err0_b, err1_b, strobe_b;
  logic [31:0] rdata0_b, rdata1_b, wdat_out_b;
  logic [7:0]  raddr_b, waddr_b;

  ps2_mouse_reg_arbiter #(.NUM_REGS(5), .STROBE_CYCLES(3)) dut3 (
    .Clk(Clk), .Reset(Reset),
    .Req0(req_b), .Req1(1'b0), .Wr0(wr_b), .Wr1(1'b0),
    .Addr0(addr_b), .Addr1(8'h00), .WData0(wdata_b), .WData1(32'h0),
    .Ack0(ack0_b), .Ack1(ack1_b), .Err0(err0_b), .Err1(err1_b),
    .RData0(rdata0_b), .RData1(rdata1_b),
    .RegReadAddress(raddr_b), .RegWriteAddress(waddr_b),
    .RegDataIn(wdat_out_b), .RegWriteData(strobe_b), .RegDataOut(32'h0)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // One isolated access; cycle 1 is the first cycle after the request is sampled.
  task automatic do_access(input logic port, input logic wr, input logic [7:0] addr,
                           input logic [31:0] wdata, output int lat, output logic err,
                           output logic [31:0] rdata, output int strobes,
                           output int first_strobe, output int wrong_acks);
    lat = -1; err = 1'b0; rdata = 32'h0; strobes = 0; first_strobe = -1; wrong_acks = 0;
    @(posedge Clk); #1;
    if (port) begin
      Req1 = 1'b1; Wr1 = wr; Addr1 = addr; WData1 = wdata;
    end else begin
      Req0 = 1'b1; Wr0 = wr; Addr0 = addr; WData0 = wdata;
    end
    for (int c = 1; c <= 20 && lat < 0; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        // Drop the request and scramble the inputs: the command must be latched.
        Req0 = 1'b0; Req1 = 1'b0;
        Addr0 = ~addr; Addr1 = ~addr; WData0 = ~wdata; WData1 = ~wdata; Wr0 = ~wr; Wr1 = ~wr;
      end
      if (RegWriteData) begin
        strobes++;
        if (first_strobe < 0) first_strobe = c;
      end
      if (port ? Ack0 : Ack1) wrong_acks++;
      if (port ? Ack1 : Ack0) begin
        lat   = c;
        err   = port ? Err1 : Err0;
        rdata = port ? RData1 : RData0;
      end
    end
  endtask

  typedef struct {
    logic        port;
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    int          lat;
    logic        err;
    logic [31:0] rdata;
    logic        chk_rdata;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, strobes, first_strobe, wrong_acks;
    logic        err;
    logic [31:0] rdata;
    logic [10:0] strobe_mask, ack_mask;
    int          unstable;
    int          n_acks;
    int          ack_cyc  [4];
    logic        ack_port [4];
    logic [31:0] ack_rd   [4];
    logic        ack_err  [4];
    int          both_acks;

    //            port  wr    addr   wdata          lat          err   rdata                     chk
    vecs[0]  = '{1'b0, 1'b1, 8'h03, 32'h00000010, 4,           1'b0, 32'h0,                    1'b0};
    vecs[1]  = '{1'b0, 1'b0, 8'h03, 32'h0,        3,           1'b0, 32'h00000010,             1'b1};
    vecs[2]  = '{1'b1, 1'b0, 8'h07, 32'h0,        1,           1'b1, 32'h0,                    1'b1};
    vecs[3]  = '{1'b1, 1'b1, 8'h04, 32'hABCD1234, Wp ? 1 : 4,  Wp,   32'h0,                    1'b0};
    vecs[4]  = '{1'b1, 1'b0, 8'h04, 32'h0,        3,           1'b0, Wp ? 32'h0 : 32'hABCD1234, 1'b1};
    vecs[5]  = '{1'b0, 1'b1, 8'h05, 32'h12345678, 1,           1'b1, 32'h0,                    1'b1};
    vecs[6]  = '{1'b0, 1'b0, 8'h04, 32'h0,        3,           1'b0, Wp ? 32'h0 : 32'hABCD1234, 1'b1};
    vecs[7]  = '{1'b0, 1'b1, 8'hFF, 32'hDEADBEEF, 1,           1'b1, 32'h0,                    1'b1};
    vecs[8]  = '{1'b1, 1'b1, 8'h01, 32'h00000055, Wp ? 1 : 4,  Wp,   32'h0,                    1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'h01, 32'h0,        3,           1'b0, Wp ? 32'h0 : 32'h55,      1'b1};
    vecs[10] = '{1'b0, 1'b0, 8'h00, 32'h0,        3,           1'b0, 32'h0,                    1'b1};

    Reset = 1'b0;
    Req0 = 1'b0; Req1 = 1'b0; Wr0 = 1'b0; Wr1 = 1'b0;
    Addr0 = 8'h0; Addr1 = 8'h0; WData0 = 32'h0; WData1 = 32'h0;
    req_b = 1'b0; wr_b = 1'b0; addr_b = 8'h0; wdata_b = 32'h0;
    repeat (3) @(posedge Clk);
    #1;
    check("rst Ack0", 32'(Ack0), 32'h0);
    check("rst Ack1", 32'(Ack1), 32'h0);
    check("rst Err0", 32'(Err0), 32'h0);
    check("rst Err1", 32'(Err1), 32'h0);
    check("rst RData0", RData0, 32'h0);
    check("rst RData1", RData1, 32'h0);
    check("rst RegReadAddress", 32'(RegReadAddress), 32'h0);
    check("rst RegWriteAddress", 32'(RegWriteAddress), 32'h0);
    check("rst RegDataIn", RegDataIn, 32'h0);
    check("rst RegWriteData", 32'(RegWriteData), 32'h0);
    Reset = 1'b1;

    // STROBE_CYCLES=3 write: strobe in cycles 2..4, Ack at 6, address/data stable 1..6.
    @(posedge Clk); #1;
    req_b = 1'b1; wr_b = 1'b1; addr_b = 8'h00; wdata_b = 32'hCAFE0003;
    strobe_mask = '0; ack_mask = '0; unstable = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge Clk); #1;
      if (c == 1) begin
        req_b = 1'b0; addr_b = 8'h02; wdata_b = 32'h0;
      end
      strobe_mask[c] = strobe_b;
      ack_mask[c]    = ack0_b;
      if (c <= 6 && (waddr_b !== 8'h00 || wdat_out_b !== 32'hCAFE0003)) unstable++;
      if (c == 6) check("sc3 Err0", 32'(err0_b), 32'h0);
    end
    check("sc3 strobe cycles", 32'(strobe_mask), 32'h01C);
    check("sc3 ack cycle", 32'(ack_mask), 32'h040);
    check("sc3 addr/data unstable cycles", unstable, 32'h0);

    // Table-driven single accesses on the default instance.
    for (int i = 0; i < 11; i++) begin
      do_access(vecs[i].port, vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                lat, err, rdata, strobes, first_strobe, wrong_acks);
      check($sformatf("v%0d ack latency", i), lat, vecs[i].lat);
      check($sformatf("v%0d err", i), 32'(err), 32'(vecs[i].err));
      check($sformatf("v%0d strobe count", i), strobes,
            (vecs[i].wr && !vecs[i].err) ? 32'd1 : 32'd0);
      if (strobes > 0) check($sformatf("v%0d strobe cycle", i), first_strobe, 32'd2);
      check($sformatf("v%0d other-port acks", i), wrong_acks, 32'd0);
      if (vecs[i].chk_rdata) check($sformatf("v%0d rdata", i), rdata, vecs[i].rdata);
    end
    check("write addr held", 32'(RegWriteAddress), Wp ? 32'h03 : 32'h01);
    check("write data held", RegDataIn, Wp ? 32'h10 : 32'h55);

    // Reset while the strobe is high.
    @(posedge Clk); #1;
    Req0 = 1'b1; Wr0 = 1'b1; Addr0 = 8'h02; WData0 = 32'h00000077;
    @(posedge Clk); #1;
    Req0 = 1'b0;
    @(posedge Clk); #1;
    check("midrst strobe high before reset", 32'(RegWriteData), 32'h1);
    Reset = 1'b0;
    @(posedge Clk); #1;
    check("midrst RegWriteData", 32'(RegWriteData), 32'h0);
    check("midrst Ack0", 32'(Ack0), 32'h0);
    check("midrst Ack1", 32'(Ack1), 32'h0);
    check("midrst RData0", RData0, 32'h0);
    check("midrst RData1", RData1, 32'h0);
    check("midrst RegReadAddress", 32'(RegReadAddress), 32'h0);
    check("midrst RegWriteAddress", 32'(RegWriteAddress), 32'h0);
    check("midrst RegDataIn", RegDataIn, 32'h0);
    Reset = 1'b1;

    // Both ports read continuously: port 0 first, then alternate, Acks 4 cycles apart.
    Req0 = 1'b1; Wr0 = 1'b0; Addr0 = 8'h02;
    Req1 = 1'b1; Wr1 = 1'b0; Addr1 = 8'h03;
    n_acks = 0; both_acks = 0;
    for (int c = 1; c <= 30 && n_acks < 4; c++) begin
      @(posedge Clk); #1;
      if (Ack0 && Ack1) both_acks++;
      if (Ack0 || Ack1) begin
        ack_cyc[n_acks]  = c;
        ack_port[n_acks] = Ack1;
        ack_rd[n_acks]   = Ack1 ? RData1 : RData0;
        ack_err[n_acks]  = Ack1 ? Err1 : Err0;
        n_acks++;
        if (n_acks == 4) begin
          Req0 = 1'b0; Req1 = 1'b0;
        end
      end
    end
    Req0 = 1'b0; Req1 = 1'b0;
    check("rr ack count", n_acks, 32'd4);
    check("rr simultaneous acks", both_acks, 32'd0);
    for (int k = 0; k < n_acks; k++) begin
      check($sformatf("rr%0d cycle", k), ack_cyc[k], 32'(3 + 4 * k));
      check($sformatf("rr%0d port", k), 32'(ack_port[k]), 32'(k % 2));
      check($sformatf("rr%0d rdata", k), ack_rd[k], (k % 2 == 1) ? 32'h10 : 32'h77);
      check($sformatf("rr%0d err", k), 32'(ack_err[k]), 32'h0);
    end

    repeat (2) @(posedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
